// File: rtl/conv1_pkg.sv
// Shared geometry, address widths and sequencer state encoding for the
// first convolution stage.
package conv1_pkg;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned K      = 3;
  localparam int unsigned OUT_W  = IMG_W - K + 1;
  localparam int unsigned N_FILT = 3;
  localparam int unsigned N_POS  = OUT_W * OUT_W;

  localparam int unsigned RD_AW = 6;
  localparam int unsigned WR_AW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_CONV,
    S_FLUSH,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/conv1_window_counter.sv
// Window origin / filter counters: column inner, row middle, filter outer.
// pos is the linear output position row*SIDE+col within one filter bank.
module conv1_window_counter
  import conv1_pkg::*;
#(
  parameter int unsigned SIDE  = OUT_W,
  parameter int unsigned NFILT = N_FILT,
  parameter int unsigned NPOS  = N_POS
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  output logic [2:0] row_o,
  output logic [2:0] col_o,
  output logic [1:0] filt_o,
  output logic [5:0] pos_o,
  output logic       last_o
);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [1:0] filt_q, filt_d;
  logic       col_wrap, row_wrap, filt_wrap;

  always_comb begin
    col_wrap  = (col_q == 3'(SIDE - 1));
    row_wrap  = (row_q == 3'(SIDE - 1));
    filt_wrap = (filt_q == 2'(NFILT - 1));
    col_d     = col_q;
    row_d     = row_q;
    filt_d    = filt_q;
    if (en_i) begin
      col_d = col_wrap ? '0 : col_q + 3'd1;
      if (col_wrap) begin
        row_d = row_wrap ? '0 : row_q + 3'd1;
        if (row_wrap) begin
          filt_d = filt_wrap ? '0 : filt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_q  <= '0;
      col_q  <= '0;
      filt_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      filt_q <= filt_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign filt_o = filt_q;
  assign pos_o  = 6'(row_q) * 6'(SIDE) + 6'(col_q);
  assign last_o = filt_wrap && (pos_o == 6'(NPOS - 1));

endmodule

// File: rtl/conv1_sequencer.sv
// Conv stage 1 control: loads the input tensor from BRAM A, then issues every
// 3x3 window for each filter and drives the delayed BRAM B write.
module conv1_sequencer
  import conv1_pkg::*;
#(
  parameter int unsigned IMG_W  = conv1_pkg::IMG_W,
  parameter int unsigned K      = conv1_pkg::K,
  parameter int unsigned N_FILT = conv1_pkg::N_FILT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             rd_en,
  output logic [RD_AW-1:0] rd_addr,
  output logic             ld_we,
  output logic [RD_AW-1:0] ld_addr,
  output logic [2:0]       win_row,
  output logic [2:0]       win_col,
  output logic [1:0]       filt_sel,
  output logic             wr_en,
  output logic [WR_AW-1:0] wr_addr,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SIDE = IMG_W - K + 1;

  seq_state_t       state_q, state_d;
  logic [RD_AW-1:0] rd_q, rd_d;
  logic             ld_we_q;
  logic [RD_AW-1:0] ld_addr_q;
  logic             pend_q, pend_d;
  logic [WR_AW-1:0] wr_addr_q, wr_addr_d;
  logic             issue, last;
  logic [5:0]       pos;

  assign issue = (state_q == S_CONV) && !stall;

  conv1_window_counter #(
    .SIDE  (SIDE),
    .NFILT (N_FILT),
    .NPOS  (SIDE * SIDE)
  ) u_win (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (issue),
    .row_o   (win_row),
    .col_o   (win_col),
    .filt_o  (filt_sel),
    .pos_o   (pos),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        rd_d = rd_q + 1'b1;
        if (rd_q == RD_AW'(IMG_W * IMG_W - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_CONV;
      S_CONV:  if (issue && last) state_d = S_FLUSH;
      S_FLUSH: if (!stall) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A stalled write stays parked in the pending register until stall drops.
  always_comb begin
    pend_d    = pend_q;
    wr_addr_d = wr_addr_q;
    if (!stall) begin
      pend_d    = (state_q == S_CONV);
      wr_addr_d = {filt_sel, pos};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      ld_we_q   <= 1'b0;
      ld_addr_q <= '0;
      pend_q    <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      ld_we_q   <= rd_en;
      ld_addr_q <= rd_addr;
      pend_q    <= pend_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign rd_en   = (state_q == S_LOAD);
  assign rd_addr = rd_q;
  assign ld_we   = ld_we_q;
  assign ld_addr = ld_addr_q;
  assign wr_en   = pend_q && !stall;
  assign wr_addr = wr_addr_q;
  assign busy    = (state_q == S_LOAD) || (state_q == S_DRAIN) ||
                   (state_q == S_CONV) || (state_q == S_FLUSH);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_conv1_sequencer.sv
// Bench for conv1_sequencer: table of pass scenarios with a write-address
// scoreboard, plus a hand-written mid-pass reset sequence.
module tb_conv1_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stall;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       ld_we;
  logic [5:0] ld_addr;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic [1:0] filt_sel;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       busy;
  logic       done;

  conv1_sequencer #(
    .IMG_W  (8),
    .K      (3),
    .N_FILT (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .win_row  (win_row),
    .win_col  (win_col),
    .filt_sel (filt_sel),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int stall_k0;   // first stalled cycle, counted from the start cycle
    int stall_len;
    bit hold;       // keep start high for the whole pass
    int exp_done;   // cycle offset of the done pulse
    int exp_writes;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) sb.push_back(8'((i / 36) * 64 + (i % 36)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_ld_we"}, ld_we, 0);
    chk({tag, "_ld_addr"}, ld_addr, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_filt_sel"}, filt_sel, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Pops the scoreboard on every write; while stalled the parked write must
  // be visible on wr_addr with wr_en low.
  task automatic sb_cycle(input int k, inout int nwr);
    if (stall && k >= 67 && sb.size() > 0) begin
      chk("stall_wr_en", wr_en, 0);
      chk("held_wr_addr", wr_addr, sb[0]);
    end
    if (wr_en) begin
      nwr++;
      chk("write_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("wr_addr", wr_addr, sb.pop_front());
    end
  endtask

  // Entered just after a negedge in IDLE; that cycle is the start cycle.
  task automatic run_pass(input vec_t v);
    int iss = 0;
    int nwr = 0;
    int exp_iss;
    push_writes(108);
    start = 1'b1;
    for (int k = 1; k <= v.exp_done + 1; k++) begin
      @(negedge clk);
      stall = (k >= v.stall_k0) && (k < v.stall_k0 + v.stall_len);
      start = v.hold;
      #1;
      if (k <= 64) begin
        chk("rd_en", rd_en, 1);
        chk("rd_addr", rd_addr, k - 1);
      end else begin
        chk("rd_en_off", rd_en, 0);
      end
      if (k >= 2 && k <= 65) begin
        chk("ld_we", ld_we, 1);
        chk("ld_addr", ld_addr, k - 2);
      end else begin
        chk("ld_we_off", ld_we, 0);
      end
      chk("busy", busy, k < v.exp_done && k <= v.exp_done);
      chk("done", done, k == v.exp_done);
      if (k >= 66 && iss < 108) begin
        exp_iss = iss;
        chk("filt_sel", filt_sel, exp_iss / 36);
        chk("win_row", win_row, (exp_iss % 36) / 6);
        chk("win_col", win_col, exp_iss % 6);
        if (!stall) iss++;
      end
      if (k == v.exp_done) begin
        chk("done_win_row", win_row, 0);
        chk("done_win_col", win_col, 0);
        chk("done_filt_sel", filt_sel, 0);
      end
      sb_cycle(k, nwr);
    end
    stall = 1'b0;
    start = v.hold;
    chk("queue_empty", sb.size(), 0);
    chk("write_count", nwr, v.exp_writes);
    sb.delete();
  endtask

  // Reset lands in the cycle of issue 70: writes 0..69 retire, 70 is dropped.
  task automatic reset_midpass();
    int nwr = 0;
    push_writes(70);
    start = 1'b1;
    for (int k = 1; k <= 136; k++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (k == 136);
      #1;
      sb_cycle(k, nwr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("post_reset");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      chk("post_reset_wr_en", wr_en, 0);
      chk("post_reset_busy", busy, 0);
    end
    chk("reset_queue_empty", sb.size(), 0);
    chk("reset_write_count", nwr, 70);
    sb.delete();
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{stall_k0: 0,   stall_len: 0,  hold: 1'b0, exp_done: 175, exp_writes: 108};
    vecs[1] = '{stall_k0: 107, stall_len: 5,  hold: 1'b0, exp_done: 180, exp_writes: 108};
    vecs[2] = '{stall_k0: 5,   stall_len: 20, hold: 1'b0, exp_done: 175, exp_writes: 108};
    vecs[3] = '{stall_k0: 67,  stall_len: 2,  hold: 1'b0, exp_done: 177, exp_writes: 108};
    vecs[4] = '{stall_k0: 174, stall_len: 3,  hold: 1'b0, exp_done: 178, exp_writes: 108};
    vecs[5] = '{stall_k0: 0,   stall_len: 0,  hold: 1'b1, exp_done: 175, exp_writes: 108};
    vecs[6] = '{stall_k0: 0,   stall_len: 0,  hold: 1'b0, exp_done: 175, exp_writes: 108};

    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_zero("idle");

    for (int i = 0; i < 7; i++) run_pass(vecs[i]);

    @(negedge clk);
    #1;
    reset_midpass();
    run_pass(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
